// File: rtl/seg7_sequencer.sv
// Frame sequencer feeding the 7-segment pattern decoder: prescaler, per-pattern frame lengths,
// pause/single-step and auto-cycling. Define SEQ_PINGPONG_EN for up/down (ping-pong) sweeps.
module seg7_sequencer #(
  parameter int unsigned      DIV_W    = 24,
  parameter logic [DIV_W-1:0] BASE_DIV = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] speed,
  input  logic [2:0] mode_sel,
  input  logic       mode_load,
  input  logic       auto_en,
  input  logic       pause,
  input  logic       step,
  output logic [3:0] counter,
  output logic [2:0] animation,
  output logic       frame_tick,
  output logic       wrap
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       anim_q, anim_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
`ifdef SEQ_PINGPONG_EN
  logic             dir_up_q, dir_up_d;
`endif

  logic [DIV_W-1:0] period_raw;
  logic [DIV_W-1:0] period_m1;
  logic [3:0]       len_m1;
  logic             tc;
  logic             adv;

  // Index of the last frame of each pattern (frame length minus one).
  function automatic logic [3:0] frame_last(input logic [2:0] pattern);
    case (pattern)
      3'd0:    frame_last = 4'd9;
      3'd1:    frame_last = 4'd11;
      3'd7:    frame_last = 4'd1;
      default: frame_last = 4'd5;
    endcase
  endfunction

  // Shifting by 2*speed divides the base period by 1, 4, 16 or 64; never below one clk.
  always_comb begin
    period_raw = BASE_DIV >> {speed, 1'b0};
    period_m1  = (period_raw == '0) ? '0 : period_raw - DIV_ONE;
    len_m1     = frame_last(anim_q);
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    anim_d  = anim_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    tc      = 1'b0;
    adv     = 1'b0;
`ifdef SEQ_PINGPONG_EN
    dir_up_d = dir_up_q;
`endif

    if (ena) begin
      case (state_q)
        ST_RUN: begin
          // >= rather than == lets a faster speed take effect even if the count is already past it.
          tc      = (presc_q >= period_m1);
          presc_d = tc ? '0 : presc_q + DIV_ONE;
          adv     = tc;
          if (pause) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          adv = step;
          if (!pause) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
      endcase

      if (mode_load) begin
        anim_d  = mode_sel;
        cnt_d   = '0;
        presc_d = '0;
`ifdef SEQ_PINGPONG_EN
        dir_up_d = 1'b1;
`endif
      end else if (adv) begin
        tick_d = 1'b1;
`ifdef SEQ_PINGPONG_EN
        if (dir_up_q) begin
          if (cnt_q >= len_m1) begin
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == len_m1) dir_up_d = 1'b0;
          end
        end else begin
          if (cnt_q <= 4'd1 || cnt_q > len_m1) wrap_d = 1'b1;
          else                                 cnt_d  = cnt_q - 4'd1;
        end
`else
        if (cnt_q >= len_m1) wrap_d = 1'b1;
        else                 cnt_d  = cnt_q + 4'd1;
`endif
        if (wrap_d) begin
          cnt_d = '0;
          if (auto_en) anim_d = anim_q + 3'd1;
`ifdef SEQ_PINGPONG_EN
          dir_up_d = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      presc_q <= '0;
      cnt_q   <= '0;
      anim_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      anim_q  <= anim_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
`ifdef SEQ_PINGPONG_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  assign counter    = cnt_q;
  assign animation  = anim_q;
  assign frame_tick = tick_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg7_sequencer.sv
// Self-checking bench for seg7_sequencer: a frame-position model checked every cycle,
// plus directed scenarios with hand-computed expectations. Honours SEQ_PINGPONG_EN.
module tb_seg7_sequencer;

  localparam logic [23:0] BASE_DIV = 24'd64;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] speed;
  logic [2:0] mode_sel;
  logic       mode_load;
  logic       auto_en;
  logic       pause;
  logic       step;
  logic [3:0] counter;
  logic [2:0] animation;
  logic       frame_tick;
  logic       wrap;

  int n_checks = 0;
  int n_errors = 0;

  int exp_periods[4] = '{64, 16, 4, 1};
`ifdef SEQ_PINGPONG_EN
  int exp_seq6[10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
  localparam int WRAP40_CNT   = 8;
  localparam int WRAP40_WRAPS = 0;
  localparam int AUTO10_ANIM  = 0;
  localparam int AUTO10_CNT   = 8;
`else
  int exp_seq6[10] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
  localparam int WRAP40_CNT   = 0;
  localparam int WRAP40_WRAPS = 1;
  localparam int AUTO10_ANIM  = 1;
  localparam int AUTO10_CNT   = 0;
`endif

  seg7_sequencer #(
    .DIV_W   (24),
    .BASE_DIV(BASE_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .speed     (speed),
    .mode_sel  (mode_sel),
    .mode_load (mode_load),
    .auto_en   (auto_en),
    .pause     (pause),
    .step      (step),
    .counter   (counter),
    .animation (animation),
    .frame_tick(frame_tick),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: position within the frame sequence, not a counter register.
  int m_phase = 0;
  int m_anim  = 0;
  int m_presc = 0;
  bit m_hold  = 1'b0;
  bit m_tick  = 1'b0;
  bit m_wrap  = 1'b0;

  function automatic int frame_len(input int pat);
    if (pat == 0) return 10;
    if (pat == 1) return 12;
    if (pat == 7) return 2;
    return 6;
  endfunction

  function automatic int seq_len(input int pat);
`ifdef SEQ_PINGPONG_EN
    return 2 * (frame_len(pat) - 1);
`else
    return frame_len(pat);
`endif
  endfunction

  function automatic int frame_of(input int pat, input int ph);
`ifdef SEQ_PINGPONG_EN
    int l;
    l = frame_len(pat);
    return (ph < l) ? ph : 2 * (l - 1) - ph;
`else
    return ph + 0 * pat;
`endif
  endfunction

  function automatic int period_of(input int s);
    int p;
    p = int'(BASE_DIV) >> (2 * s);
    return (p < 1) ? 1 : p;
  endfunction

  initial begin
    int per;
    bit adv;
    bit hold_nx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_anim = 0; m_presc = 0;
        m_hold  = 1'b0; m_tick = 1'b0; m_wrap = 1'b0;
      end else begin
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (ena) begin
          adv     = 1'b0;
          hold_nx = m_hold;
          if (!m_hold) begin
            per = period_of(int'(speed));
            if (m_presc >= per - 1) begin
              adv     = 1'b1;
              m_presc = 0;
            end else begin
              m_presc++;
            end
            if (pause) hold_nx = 1'b1;
          end else begin
            adv = step;
            if (!pause) begin
              hold_nx = 1'b0;
              m_presc = 0;
            end
          end
          if (mode_load) begin
            m_anim  = int'(mode_sel);
            m_phase = 0;
            m_presc = 0;
          end else if (adv) begin
            m_tick  = 1'b1;
            m_phase = (m_phase + 1) % seq_len(m_anim);
            if (m_phase == 0) begin
              m_wrap = 1'b1;
              if (auto_en) m_anim = (m_anim + 1) % 8;
            end
          end
          m_hold = hold_nx;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1)
        check("cycle", {23'd0, counter, animation, frame_tick, wrap},
              {23'd0, 4'(frame_of(m_anim, m_phase)), 3'(m_anim), m_tick, m_wrap});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic load(input logic [2:0] pat);
    mode_sel  = pat;
    mode_load = 1'b1;
    @(negedge clk);
    mode_load = 1'b0;
  endtask

  task automatic wait_counter(input logic [3:0] target, input int limit);
    int n = 0;
    while (counter !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_counter", 32'(counter === target), 32'd1);
  endtask

  task automatic measure_period(output int p);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      p = -1;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 300);
    p = n;
  endtask

  initial begin
    int ticks;
    int wraps;
    int p;
    rst_n = 1'b0; ena = 1'b1; speed = 2'd2; mode_sel = 3'd0; mode_load = 1'b0;
    auto_en = 1'b0; pause = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_outputs", {23'd0, counter, animation, frame_tick, wrap}, 32'd0);

    // Period 4: the first frame advance lands on the fourth edge.
    ticks = 0;
    repeat (4) begin
      @(negedge clk);
      ticks += int'(frame_tick);
    end
    check("first_frame_counter", 32'(counter), 32'd1);
    check("first_frame_ticks", 32'(ticks), 32'd1);

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {23'd0, counter, animation, frame_tick, wrap}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ten frames of pattern 0.
    ticks = 0;
    wraps = 0;
    repeat (40) begin
      @(negedge clk);
      ticks += int'(frame_tick);
      wraps += int'(wrap);
    end
    check("wrap40_ticks", 32'(ticks), 32'd10);
    check("wrap40_wraps", 32'(wraps), 32'(WRAP40_WRAPS));
    check("wrap40_counter", 32'(counter), 32'(WRAP40_CNT));
    check("wrap40_anim", 32'(animation), 32'd0);

    // Auto-cycle from pattern 7 at one frame per clk.
    speed   = 2'd3;
    auto_en = 1'b1;
    load(3'd7);
    check("load7_anim", 32'(animation), 32'd7);
    check("load7_counter", 32'(counter), 32'd0);
    repeat (2) @(negedge clk);
    check("auto_wrap_flag", 32'(wrap), 32'd1);
    check("auto_wrap_anim", 32'(animation), 32'd0);
    check("auto_wrap_counter", 32'(counter), 32'd0);
    repeat (10) @(negedge clk);
    check("auto10_anim", 32'(animation), 32'(AUTO10_ANIM));
    check("auto10_counter", 32'(counter), 32'(AUTO10_CNT));
    auto_en = 1'b0;

    // Global enable freezes everything.
    load(3'd0);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    check("ena_hold_counter", 32'(counter), 32'd2);
    check("ena_hold_tick", 32'(frame_tick), 32'd0);
    ena = 1'b1;

    for (int s = 0; s < 4; s++) begin
      speed = 2'(s);
      load(3'd0);
      measure_period(p);
      check($sformatf("period_speed%0d", s), 32'(p), 32'(exp_periods[s]));
    end

    // Switching to a shorter period when already past it forces an immediate advance.
    speed = 2'd0;
    load(3'd0);
    repeat (20) @(negedge clk);
    speed = 2'd2;
    @(negedge clk);
    check("speed_change_tick", 32'(frame_tick), 32'd1);
    check("speed_change_counter", 32'(counter), 32'd1);

    // Pause / single step.
    load(3'd0);
    wait_counter(4'd3, 100);
    pause = 1'b1;
    repeat (100) @(negedge clk);
    check("pause_counter", 32'(counter), 32'd3);
    ticks = 0;
    repeat (2) begin
      step = 1'b1;
      @(negedge clk);
      ticks += int'(frame_tick);
      step = 1'b0;
      @(negedge clk);
      ticks += int'(frame_tick);
    end
    check("step_counter", 32'(counter), 32'd5);
    check("step_ticks", 32'(ticks), 32'd2);
    pause = 1'b0;
    p = 0;
    do begin
      @(negedge clk);
      p++;
    end while (frame_tick !== 1'b1 && p < 50);
    check("resume_latency", 32'(p), 32'd5);

    // mode_load collides with the advance out of the last frame.
    auto_en = 1'b1;
    load(3'd0);
    wait_counter(4'd9, 100);
    repeat (3) @(negedge clk);
    load(3'd2);
    check("prio_anim", 32'(animation), 32'd2);
    check("prio_counter", 32'(counter), 32'd0);
    check("prio_tick", 32'(frame_tick), 32'd0);
    check("prio_wrap", 32'(wrap), 32'd0);
    auto_en = 1'b0;

    // Length-6 sequence.
    speed = 2'd3;
    load(3'd2);
    wraps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wraps += int'(wrap);
      check($sformatf("len6_frame%0d", i), 32'(counter), 32'(exp_seq6[i]));
    end
    check("len6_wraps", 32'(wraps), 32'd1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
